multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset CPU.
- Sequences one shared ALU, one unified instruction/data memory, the IR, the PC and the register file over 3-5 cycles per instruction.
- Replaces the combinational opcode decode of the single-cycle core.
- Adds a memory-ready handshake, trap on illegal opcode, and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 90 +++++++++
 rtl/multicycle_outdec.sv | 107 ++++++++++
 rtl/multicycle_ctrl.sv | 103 ++++++++++
 tb/tb_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-subset CPU control path.
// Holds opcode values, the multi-cycle FSM state encodings, the datapath
// mux/ALU select encodings and the control-word struct. The single-cycle
// decoder imports the same opcode and select encodings.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Multi-cycle FSM states; the values are visible on state_o for debug.
  localparam logic [3:0] S_IF   = 4'd0;
  localparam logic [3:0] S_ID   = 4'd1;
  localparam logic [3:0] S_MADR = 4'd2;
  localparam logic [3:0] S_MRD  = 4'd3;
  localparam logic [3:0] S_MWB  = 4'd4;
  localparam logic [3:0] S_MWR  = 4'd5;
  localparam logic [3:0] S_EXR  = 4'd6;
  localparam logic [3:0] S_RWB  = 4'd7;
  localparam logic [3:0] S_EXI  = 4'd8;
  localparam logic [3:0] S_IWB  = 4'd9;
  localparam logic [3:0] S_BR   = 4'd10;
  localparam logic [3:0] S_JMP  = 4'd11;
  localparam logic [3:0] S_TRAP = 4'd12;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b110;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Full control word produced by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Dispatch out of ID by instruction class; unknown opcodes trap.
  function automatic logic [3:0] id_next_state(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:     return S_MADR;
      OP_RTYPE:         return S_EXR;
      OP_ADDI, OP_SLTI: return S_EXI;
      OP_BEQ, OP_BNE:   return S_BR;
      OP_J, OP_JAL:     return S_JMP;
      default:          return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// multicycle_outdec: combinational control-output decoder for the
// multi-cycle FSM. Mostly a Moore decode of the state; the opcode refines
// EXI/BR/JMP, and mem_ready_i / zero_i feed the few Mealy terms
// (IRWrite/PCWrite in IF, done in MWR, branch-taken PCWrite in BR).
// Ports:
//   state_i      current FSM state
//   op_i         opcode from the IR
//   zero_i       ALU zero flag
//   mem_ready_i  memory completes the current access this cycle
//   ctrl_o       full control word
module multicycle_outdec
  import mips_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    // NOTE: zero the whole word first so every path assigns every field; no latches.
    ctrl_o = '0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        // IR and PC+4 are captured only in the cycle the fetch completes.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_ID: begin
        // Speculatively form the branch target into ALUOut.
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.instr_done = 1'b1;
      end
      S_MWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXI: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_BR: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_REGB;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_src     = PCSRC_ALUOUT;
        ctrl_o.pc_write   = (op_i == OP_BNE) ? ~zero_i : zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
        // jal links PC+4, which the PC already holds since IF.
        if (op_i == OP_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = REGDST_R31;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-subset CPU.
// Holds the state register, next-state logic and the retired-instruction
// counter; control outputs come from multicycle_outdec.
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   instr_op_i            opcode from IR[31:26]
//   zero_i                ALU zero flag
//   mem_ready_i           memory access completes this cycle
//   PCWrite_o..ALU_op_o   datapath controls
//   instr_done_o          pulse in the last cycle of each instruction
//   illegal_o             high while trapped on an illegal opcode
//   state_o               current state (debug)
//   retired_o             completed-instruction count, wraps
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic [1:0]       PCSrc_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       RegDst_o,
  output logic [1:0]       MemtoReg_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;

  multicycle_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (instr_op_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ready_i) state_d = S_ID;
      S_ID:   state_d = id_next_state(instr_op_i);
      S_MADR: state_d = (instr_op_i == OP_LW) ? S_MRD : S_MWR;
      S_MRD:  if (mem_ready_i) state_d = S_MWB;
      S_MWR:  if (mem_ready_i) state_d = S_IF;
      S_EXR:  state_d = S_RWB;
      S_EXI:  state_d = S_IWB;
      S_MWB, S_RWB, S_IWB, S_BR, S_JMP: state_d = S_IF;
      // TRAP is only left through reset.
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  // Natural modulo-2^CNT_W wrap after all-ones.
  always_comb retired_d = retired_q + CNT_W'(ctrl.instr_done);

  // NOTE: state uses non-blocking assignments and an async reset so the FSM
  // drops to IF (and outputs to IF values) without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign PCWrite_o    = ctrl.pc_write;
  assign PCSrc_o      = ctrl.pc_src;
  assign IorD_o       = ctrl.iord;
  assign MemRead_o    = ctrl.mem_read;
  assign MemWrite_o   = ctrl.mem_write;
  assign IRWrite_o    = ctrl.ir_write;
  assign RegWrite_o   = ctrl.reg_write;
  assign RegDst_o     = ctrl.reg_dst;
  assign MemtoReg_o   = ctrl.mem_to_reg;
  assign ALUSrcA_o    = ctrl.alu_src_a;
  assign ALUSrcB_o    = ctrl.alu_src_b;
  assign ALU_op_o     = ctrl.alu_op;
  assign instr_done_o = ctrl.instr_done;
  assign illegal_o    = ctrl.illegal;
  assign state_o      = state_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// Each instruction is expanded into its expected per-cycle path (state,
// memory-ready value, opcode, zero flag); a compare process checks state,
// all control outputs and the retired count on every cycle. A second
// instance with a 2-bit counter exercises counter wrap.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       zero_i;
  logic       mem_ready_i;

  logic        PCWrite_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o;
  logic        ALUSrcA_o, instr_done_o, illegal_o;
  logic [1:0]  PCSrc_o, RegDst_o, MemtoReg_o, ALUSrcB_o;
  logic [2:0]  ALU_op_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  logic        w_pcw, w_iord, w_mrd, w_mwr, w_irw, w_rw, w_srca, w_done, w_ill;
  logic [1:0]  w_pcsrc, w_rdst, w_m2r, w_srcb;
  logic [2:0]  w_aop;
  logic [3:0]  w_state;
  logic [1:0]  w_retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .RegDst_o(RegDst_o),
    .MemtoReg_o(MemtoReg_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALU_op_o(ALU_op_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .state_o(state_o), .retired_o(retired_o)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(w_pcw), .PCSrc_o(w_pcsrc),
    .IorD_o(w_iord), .MemRead_o(w_mrd), .MemWrite_o(w_mwr),
    .IRWrite_o(w_irw), .RegWrite_o(w_rw), .RegDst_o(w_rdst),
    .MemtoReg_o(w_m2r), .ALUSrcA_o(w_srca), .ALUSrcB_o(w_srcb),
    .ALU_op_o(w_aop), .instr_done_o(w_done), .illegal_o(w_ill),
    .state_o(w_state), .retired_o(w_retired)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    logic [5:0] op;
  } cyc_t;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aop;
    logic       done, ill;
  } exp_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic        cmp_valid = 1'b0;
  logic [31:0] model_ret = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Required control outputs for one cycle, straight from the state table.
  function automatic exp_t exp_outputs(input logic [3:0] st, input logic [5:0] op,
                                       input logic z, input logic rdy);
    exp_t e;
    e = '0;
    case (st)
      4'd0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      4'd1:  e.srcb = 2'b11;
      4'd2:  begin e.srca = 1; e.srcb = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 2'b01; e.done = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
      4'd6:  begin e.srca = 1; e.aop = 3'b110; end
      4'd7:  begin e.rw = 1; e.rdst = 2'b01; e.done = 1; end
      4'd8:  begin e.srca = 1; e.srcb = 2'b10; e.aop = (op == 6'b001010) ? 3'b101 : 3'b000; end
      4'd9:  begin e.rw = 1; e.done = 1; end
      4'd10: begin
        e.srca = 1; e.aop = 3'b001; e.pcsrc = 2'b01; e.done = 1;
        e.pcw = (op == 6'b000101) ? !z : z;
      end
      4'd11: begin
        e.pcw = 1; e.pcsrc = 2'b10; e.done = 1;
        if (op == 6'b000011) begin e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; end
      end
      4'd12: e.ill = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op, input logic z);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = op; c.z = z;
    q.push_back(c);
  endtask

  // Expand one instruction into its expected cycle path. Non-memory states
  // get a random mem_ready_i, which must have no effect.
  task automatic add_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait,
                           input logic z, input int trap_cycles, output int ncyc);
    int n0;
    n0 = q.size();
    repeat (fetch_wait) push(4'd0, 1'b0, op, rnd());
    push(4'd0, 1'b1, op, rnd());
    push(4'd1, rnd(), op, rnd());
    case (op)
      6'b100011: begin
        push(4'd2, rnd(), op, rnd());
        repeat (mem_wait) push(4'd3, 1'b0, op, rnd());
        push(4'd3, 1'b1, op, rnd());
        push(4'd4, rnd(), op, rnd());
      end
      6'b101011: begin
        push(4'd2, rnd(), op, rnd());
        repeat (mem_wait) push(4'd5, 1'b0, op, rnd());
        push(4'd5, 1'b1, op, rnd());
      end
      6'b000000: begin push(4'd6, rnd(), op, rnd()); push(4'd7, rnd(), op, rnd()); end
      6'b001000, 6'b001010: begin push(4'd8, rnd(), op, rnd()); push(4'd9, rnd(), op, rnd()); end
      6'b000100, 6'b000101: push(4'd10, rnd(), op, z);
      6'b000010, 6'b000011: push(4'd11, rnd(), op, rnd());
      default: repeat (trap_cycles) push(4'd12, rnd(), op, rnd());
    endcase
    ncyc = q.size() - n0;
  endtask

  // Drive up to ncyc queued cycles, then one idle edge with mem_ready_i low.
  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc && q.size() > 0; i++) begin
      @(posedge clk_i);
      #1;
      cur         = q.pop_front();
      instr_op_i  = cur.op;
      zero_i      = cur.z;
      mem_ready_i = cur.rdy;
      cmp_valid   = 1'b1;
    end
    @(posedge clk_i);
    #1;
    cmp_valid   = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  // Compare process: every driven cycle, mid-period.
  always @(negedge clk_i or negedge rst_i) begin
    exp_t e;
    if (!rst_i) begin
      model_ret = '0;
    end else if (cmp_valid) begin
      e = exp_outputs(cur.st, cur.op, cur.z, cur.rdy);
      check($sformatf("state st%0d", cur.st), 32'(state_o), 32'(cur.st));
      check($sformatf("outputs st%0d", cur.st),
            32'({PCWrite_o, PCSrc_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o,
                 RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, instr_done_o, illegal_o}),
            32'(e));
      check($sformatf("retired st%0d", cur.st), retired_o, model_ret);
      check($sformatf("retired_wrap st%0d", cur.st), 32'(w_retired), 32'(model_ret[1:0]));
      if (e.done) model_ret = model_ret + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0; instr_op_i = 6'b0;
    #2;
    check("reset state", 32'(state_o), 32'd0);
    check("reset retired", retired_o, 32'd0);
    check("reset MemRead", 32'(MemRead_o), 32'd1);
    check("reset ALUSrcB", 32'(ALUSrcB_o), 32'd1);
    check("reset IRWrite", 32'(IRWrite_o), 32'd0);
    #20 rst_i = 1'b1;

    // R-type, memory ready immediately
    add_instr(6'b000000, 0, 0, 1'b0, 0, n);
    check("r_cycles", 32'(n), 32'd4);
    run(q.size());
    check("r_retired", retired_o, 32'd1);

    // lw with two MRD wait cycles
    add_instr(6'b100011, 0, 2, 1'b0, 0, n);
    check("lw_cycles", 32'(n), 32'd7);
    run(q.size());
    check("lw_retired", retired_o, 32'd2);

    // Branches, taken and not taken
    add_instr(6'b000100, 0, 0, 1'b1, 0, n);
    check("beq_cycles", 32'(n), 32'd3);
    add_instr(6'b000101, 0, 0, 1'b1, 0, n);
    check("bne_cycles", 32'(n), 32'd3);
    add_instr(6'b000100, 0, 0, 1'b0, 0, n);
    add_instr(6'b000101, 0, 0, 1'b0, 0, n);
    run(q.size());

    // Jumps, immediates with a fetch stall, sw with one write stall
    add_instr(6'b000011, 0, 0, 1'b0, 0, n);
    check("jal_cycles", 32'(n), 32'd3);
    add_instr(6'b000010, 0, 0, 1'b0, 0, n);
    add_instr(6'b001000, 1, 0, 1'b0, 0, n);
    check("addi_stall_cycles", 32'(n), 32'd5);
    add_instr(6'b001010, 0, 0, 1'b0, 0, n);
    add_instr(6'b101011, 0, 1, 1'b0, 0, n);
    check("sw_stall_cycles", 32'(n), 32'd5);
    run(q.size());
    check("mix_retired", retired_o, 32'd11);
    check("wrap_retired", 32'(w_retired), 32'd3);

    // Async reset while in MWR (held there by mem_ready_i low)
    add_instr(6'b101011, 0, 5, 1'b0, 0, n);
    run(5);
    check("pre_rst state", 32'(state_o), 32'd5);
    #2 rst_i = 1'b0;
    #1;
    check("midsw state", 32'(state_o), 32'd0);
    check("midsw retired", retired_o, 32'd0);
    check("midsw MemWrite", 32'(MemWrite_o), 32'd0);
    check("midsw IorD", 32'(IorD_o), 32'd0);
    check("midsw MemRead", 32'(MemRead_o), 32'd1);
    q.delete();
    @(negedge clk_i);
    #1 rst_i = 1'b1;

    add_instr(6'b000000, 0, 0, 1'b0, 0, n);
    run(q.size());
    check("post_rst retired", retired_o, 32'd1);

    // Illegal opcode: TRAP for 20 cycles, left only by reset
    add_instr(6'b111111, 0, 0, 1'b0, 20, n);
    check("trap_cycles", 32'(n), 32'd22);
    run(q.size());
    check("trap state", 32'(state_o), 32'd12);
    check("trap illegal", 32'(illegal_o), 32'd1);
    check("trap retired", retired_o, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("trap_rst state", 32'(state_o), 32'd0);
    check("trap_rst illegal", 32'(illegal_o), 32'd0);
    check("trap_rst retired", retired_o, 32'd0);
    @(negedge clk_i);
    #1 rst_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
